// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch sequencer.
// Issues fetch requests at pc_o and advances the PC on each accepted instruction
// using an external +4 adder. Handles stall, jump/branch redirects and halts
// when the sequential PC overflows.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 leave IDLE and begin fetching
//   stall_i                 hold off the next fetch request
//   branch_i/branch_addr_i  branch redirect
//   jump_i/jump_addr_i      jump redirect (wins over branch)
//   pc_next_i/pc_carry_i    pc_o+4 and carry-out from the external adder
//   imem_ack_i/inst_i       memory acknowledge and instruction data
//   pc_o, imem_req_o        fetch address and request
//   inst_o, inst_valid_o    delivered instruction and its one-cycle strobe
//   fetch_cnt_o             delivered instruction count (wraps)
//   wrap_err_o              sticky sequential-overflow flag
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] pc_next_i,
  input  logic        pc_carry_i,
  input  logic        imem_ack_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [15:0] fetch_cnt_o,
  output logic        wrap_err_o
);

  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        redir_c;
  logic [31:0] redir_tgt_c;

  // Redirect requested this cycle; jump has priority over branch.
  assign redir_c     = jump_i | branch_i;
  assign redir_tgt_c = (jump_i ? jump_addr_i : branch_addr_i) & ALIGN_MASK;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    valid_d     = 1'b0;
    cnt_d       = cnt_q;
    wrap_d      = wrap_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = stall_i ? ST_STALL : ST_REQ;
        end
      end

      ST_REQ: begin
        if (imem_ack_i) begin
          if (redir_c || pend_q) begin
            // Fetched instruction is on the wrong path: drop it.
            pc_d    = redir_c ? redir_tgt_c : pend_addr_q;
            pend_d  = 1'b0;
            state_d = stall_i ? ST_STALL : ST_REQ;
          end else begin
            inst_d  = inst_i;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            if (pc_carry_i) begin
              // Sequential PC would wrap past the top of memory.
              wrap_d  = 1'b1;
              state_d = ST_HALT;
            end else begin
              pc_d    = pc_next_i & ALIGN_MASK;
              state_d = stall_i ? ST_STALL : ST_REQ;
            end
          end
        end else if (redir_c) begin
          // PC must stay put while the request is outstanding; remember the target.
          pend_d      = 1'b1;
          pend_addr_d = redir_tgt_c;
        end
      end

      ST_STALL: begin
        if (redir_c) begin
          pc_d = redir_tgt_c;
        end
        if (!stall_i) begin
          state_d = ST_REQ;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request line is the registered image of "next state is REQ".
  assign req_d = (state_d == ST_REQ);

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC_AL;
      req_q       <= 1'b0;
      inst_q      <= 32'd0;
      valid_q     <= 1'b0;
      cnt_q       <= 16'd0;
      wrap_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign pc_o         = pc_q;
  assign imem_req_o   = req_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign fetch_cnt_o  = cnt_q;
  assign wrap_err_o   = wrap_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios followed by random stimulus,
// checked against a transaction-level reference model. Delivered instructions
// are queued by the driver and matched by an independent monitor.
module tb_pc_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stall_i, branch_i, jump_i, pc_carry_i, imem_ack_i;
  logic [31:0] branch_addr_i, jump_addr_i, pc_next_i, inst_i;
  logic [31:0] pc_o, inst_o;
  logic        imem_req_o, inst_valid_o, wrap_err_o;
  logic [15:0] fetch_cnt_o;

  pc_fetch_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .pc_next_i(pc_next_i), .pc_carry_i(pc_carry_i),
    .imem_ack_i(imem_ack_i), .inst_i(inst_i),
    .pc_o(pc_o), .imem_req_o(imem_req_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o), .fetch_cnt_o(fetch_cnt_o), .wrap_err_o(wrap_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] inst;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: fetcher mode plus architectural values.
  localparam int M_IDLE = 0, M_FETCH = 1, M_PAUSE = 2, M_HALT = 3;
  int          m_mode;
  logic [31:0] m_pc, m_inst, m_pend_addr;
  logic [15:0] m_cnt;
  logic        m_wrap;
  bit          m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 32'h0; m_inst = 32'h0; m_cnt = 16'h0;
    m_wrap = 1'b0; m_pend = 1'b0; m_pend_addr = 32'h0;
  endtask

  // One clock: check current outputs, drive inputs, advance the model. Called at negedge.
  task automatic cycle(input bit rst, input bit start, input bit stall,
                       input bit br, input logic [31:0] ba,
                       input bit jp, input logic [31:0] ja,
                       input bit ack, input logic [31:0] inst);
    logic [32:0] sum;
    logic [31:0] tgt;
    bit          redir;
    chk("pc_o", pc_o, m_pc);
    chk("imem_req_o", 32'(imem_req_o), 32'(m_mode == M_FETCH));
    chk("inst_o", inst_o, m_inst);
    chk("fetch_cnt_o", 32'(fetch_cnt_o), 32'(m_cnt));
    chk("wrap_err_o", 32'(wrap_err_o), 32'(m_wrap));

    sum = {1'b0, m_pc} + 33'd4;
    rst_i = rst; start_i = start; stall_i = stall;
    branch_i = br; branch_addr_i = ba; jump_i = jp; jump_addr_i = ja;
    imem_ack_i = ack; inst_i = inst;
    pc_next_i = sum[31:0]; pc_carry_i = sum[32];

    redir = jp | br;
    tgt   = (jp ? ja : ba) & 32'hFFFF_FFFC;
    if (rst) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE:  if (start) m_mode = stall ? M_PAUSE : M_FETCH;
        M_FETCH: begin
          if (ack) begin
            if (redir || m_pend) begin
              m_pc   = redir ? tgt : m_pend_addr;
              m_pend = 1'b0;
              m_mode = stall ? M_PAUSE : M_FETCH;
            end else begin
              m_cnt  = m_cnt + 16'd1;
              m_inst = inst;
              exp_q.push_back('{inst: inst, cnt: m_cnt, cyc: cyc + 1});
              if (sum[32]) begin
                m_wrap = 1'b1;
                m_mode = M_HALT;
              end else begin
                m_pc   = m_pc + 32'd4;
                m_mode = stall ? M_PAUSE : M_FETCH;
              end
            end
          end else if (redir) begin
            m_pend = 1'b1;
            m_pend_addr = tgt;
          end
        end
        M_PAUSE: begin
          if (redir) m_pc = tgt;
          if (!stall) m_mode = M_FETCH;
        end
        default: ;
      endcase
    end
    @(negedge clk_i);
  endtask

  task automatic step(input bit start, input bit stall, input bit ack, input logic [31:0] inst);
    cycle(1'b0, start, stall, 1'b0, 32'h0, 1'b0, 32'h0, ack, inst);
  endtask

  task automatic do_reset(input bit ack);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ack, 32'hDEAD_BEEF);
  endtask

  // Monitor: each delivered instruction must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (inst_valid_o === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid @cyc %0d: got inst %0h cnt %0d expected no delivery",
                   cyc, inst_o, fetch_cnt_o);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || inst_o !== e.inst || fetch_cnt_o !== e.cnt) begin
            fails++;
            $display("FAIL delivery @cyc %0d: got inst %0h cnt %0d expected inst %0h cnt %0d at cyc %0d",
                     cyc, inst_o, fetch_cnt_o, e.inst, e.cnt, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        tests++;
        fails++;
        e = exp_q.pop_front();
        $display("FAIL missing_valid @cyc %0d: got no inst_valid_o expected inst %0h cnt %0d",
                 cyc, e.inst, e.cnt);
      end
    end
  end

  logic [31:0] ra, rb;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
    branch_addr_i = 32'h0; jump_addr_i = 32'h0; pc_next_i = 32'h4; pc_carry_i = 1'b0;
    imem_ack_i = 1'b0; inst_i = 32'h0;
    @(negedge clk_i);
    @(negedge clk_i);
    model_reset();

    // Sequential fetch with ack every cycle.
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h55);  // ack while IDLE is ignored
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b1, 32'hA0 + 32'(n));
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Wait states at pc 0x8.
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hB0);
    step(1'b0, 1'b0, 1'b1, 32'hB1);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hB2);

    // Jump beats branch; instruction discarded.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h203, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hC0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Stall on ack, branch while stalled.
    step(1'b0, 1'b1, 1'b1, 32'hC1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h41, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hC2);

    // Overflow at the top of memory, then HALT ignores everything.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'hD0);
    step(1'b0, 1'b0, 1'b1, 32'hD1);
    for (int n = 0; n < 3; n++)
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 32'hD2);

    // Reset while a request is outstanding; late ack has no effect.
    do_reset(1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b1, 32'hE0 + 32'(n));
    do_reset(1'b1);
    step(1'b0, 1'b0, 1'b1, 32'hE9);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(3) == 0) ra = 32'hFFFF_FFF0 | (ra & 32'hF);
      if ($urandom_range(3) == 0) rb = 32'hFFFF_FFF0 | (rb & 32'hF);
      cycle($urandom_range(59) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(7) == 0, ra, $urandom_range(11) == 0, rb,
            $urandom_range(1) == 0, $urandom());
    end

    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_deliveries: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
- REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
- REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded at reset; bits [1:0] are treated as 0.
- REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
- REQ-004 rst_i  in  1  synchronous, active-high reset.
- REQ-005 start_i  in  1  begins fetching from IDLE; ignored in all other states.
- REQ-006 stall_i  in  1  blocks issue of the next fetch request.
- REQ-007 branch_i  in  1  redirect request to branch_addr_i.
- REQ-008 branch_addr_i  in  32  branch target.
- REQ-009 jump_i  in  1  redirect request to jump_addr_i; has priority over branch_i.
- REQ-010 jump_addr_i  in  32  jump target.
- REQ-011 pc_next_i  in  32  pc_o+4, computed by the external 32-bit adder (data1=pc_o, data2=4, carry-in=0).
- REQ-012 pc_carry_i  in  1  carry-out of that adder.
- REQ-013 imem_ack_i  in  1  instruction memory ack; inst_i is valid in the same cycle.
- REQ-014 inst_i  in  32  instruction data from memory.
- REQ-015 pc_o  out  32  current fetch address; also the adder operand; bits [1:0] always 0.
- REQ-016 imem_req_o  out  1  fetch request, registered.
- REQ-017 inst_o  out  32  last delivered instruction, registered.
- REQ-018 inst_valid_o  out  1  one-cycle pulse marking a new inst_o.
- REQ-019 fetch_cnt_o  out  16  count of delivered instructions, wraps 16'hFFFF to 0.
- REQ-020 wrap_err_o  out  1  sticky flag: sequential PC overflowed.

Function
- REQ-021 The FSM SHALL have exactly four states: IDLE, REQ, STALL and HALT. All outputs are registered.
- REQ-022 IDLE: imem_req_o=0. If start_i=1, the next state SHALL be REQ (stall_i=0) or STALL (stall_i=1).
- REQ-023 REQ: imem_req_o=1 and pc_o SHALL stay constant until the cycle in which imem_ack_i=1; a request is never withdrawn before ack.
- REQ-024 On ack with no redirect pending or present, the block SHALL update on the next edge: inst_o<=inst_i, inst_valid_o<=1, fetch_cnt_o+1, pc_o<=pc_next_i.
- REQ-025 Next state after an ack SHALL be REQ if stall_i=0 and STALL if stall_i=1; imem_req_o follows the next state, so back-to-back fetches are possible every cycle.
- REQ-026 STALL: imem_req_o=0 and pc_o is held; the block SHALL return to REQ on the first cycle stall_i=0.
- REQ-027 Redirect target: jump_addr_i if jump_i=1, else branch_addr_i if branch_i=1; bits [1:0] SHALL be forced to 0.
- REQ-028 A redirect in STALL SHALL load pc_o on the next edge.
- REQ-029 A redirect in REQ before or with the ack SHALL be latched; the latest one wins.
- REQ-030 On the ack cycle with a redirect latched or present, the block SHALL discard the instruction (inst_valid_o=0, count unchanged) and set pc_o<=target.
- REQ-031 The block SHALL ignore redirects in IDLE and HALT.
- REQ-032 Sequential overflow: if pc_carry_i=1 on a non-redirected ack, the instruction SHALL still be delivered. In addition, pc_o holds, wrap_err_o<=1, imem_req_o<=0 and the state becomes HALT.
- REQ-033 HALT SHALL persist until rst_i; all inputs other than rst_i are ignored.
- REQ-034 imem_ack_i SHALL be ignored in IDLE, STALL and HALT.

Reset
- REQ-035 When rst_i=1 at an edge, all outputs SHALL take reset values regardless of state or outstanding request: pc_o=RESET_PC, imem_req_o=0, inst_o=0, inst_valid_o=0, fetch_cnt_o=0, wrap_err_o=0.
- REQ-036 The same reset edge SHALL set the state to IDLE and clear any latched redirect.
- REQ-037 An ack arriving after a mid-request reset SHALL have no effect.

Verification
- REQ-038 Sequential fetch: reset; start_i=1; ack every cycle with inst_i=0xA0+n -> pc_o 0,4,8,12; inst_valid_o high every cycle after the first ack; fetch_cnt_o=4 after 4 acks.
- REQ-039 Wait states: ack delayed 3 cycles -> imem_req_o and pc_o=0x8 stable for all 3 cycles; exactly one inst_valid_o pulse.
- REQ-040 Redirect priority: in REQ, branch_i=1 (0x100) and jump_i=1 (0x203) in the same cycle, then ack -> no inst_valid_o; next pc_o=0x200.
- REQ-041 Stall: stall_i=1 on the ack cycle for 2 cycles -> imem_req_o=0 for 2 cycles, pc_o held; branch to 0x40 during the stall -> first request after the stall at 0x40.
- REQ-042 Overflow: RESET_PC=0xFFFFFFFC; ack with pc_carry_i=1, pc_next_i=0 -> inst delivered; wrap_err_o=1, HALT, imem_req_o=0; start_i ignored until rst_i.
- REQ-043 Mid-request reset: rst_i in REQ at pc_o=0x10, ack next cycle -> all outputs at reset values; no inst_valid_o.
